// File: rtl/mostra_sequencia_pkg.sv
// Shared definitions for the sequence playback block: state codes and default timings.
// The game controller and the db_estado decoder use the same state codes.
package mostra_sequencia_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

    localparam int T_ACESO_DEF   = 1000;
    localparam int T_APAGADO_DEF = 500;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/mostra_sequencia_contador.sv
// contador_m: modulo-M timer with synchronous zero and enable; o_fim flags count == M-1.
module contador_m #(
    parameter int M = 2,
    parameter int W = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_zera,
    input  logic i_conta,
    output logic o_fim
);

    logic [W-1:0] r_valor;

    assign o_fim = (r_valor == W'(M - 1));

    // Count register: zero has priority over enable, wraps after M-1.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valor <= {W{1'b0}};
        end else if (i_zera) begin
            r_valor <= {W{1'b0}};
        end else if (i_conta) begin
            if (o_fim) begin
                r_valor <= {W{1'b0}};
            end else begin
                r_valor <= r_valor + W'(1);
            end
        end else begin
            r_valor <= r_valor;
        end
    end

endmodule

// File: rtl/mostra_sequencia.sv
// Plays back memory entries 0..rodada on the LEDs (lit, then dark) and pulses pronto at the end.
// Optional debug outputs db_estado/db_endereco are enabled by MOSTRA_SEQUENCIA_DB_EN.
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int T_ACESO   = T_ACESO_DEF,
    parameter int T_APAGADO = T_APAGADO_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] rodada,
    output logic [ADDR_W-1:0] mem_endereco,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
`ifdef MOSTRA_SEQUENCIA_DB_EN
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_endereco,
    output logic              pronto
`else
    output logic              pronto
`endif
);

    localparam int TMR_W = $clog2(max_int(T_ACESO, T_APAGADO) + 1);

    estado_t           r_estado;
    estado_t           w_prox_estado;
    logic [ADDR_W-1:0] r_endereco;
    logic [ADDR_W-1:0] w_prox_endereco;
    logic [ADDR_W-1:0] r_rodada;
    logic [ADDR_W-1:0] w_prox_rodada;
    logic [DATA_W-1:0] r_leds;
    logic [DATA_W-1:0] w_prox_leds;
    logic              r_ocupado;
    logic              r_pronto;
    logic              w_fim_aceso;
    logic              w_fim_apagado;

    // Each phase timer restarts from zero whenever its phase is not active.
    contador_m #(.M(T_ACESO), .W(TMR_W)) u_tmr_aceso (
        .i_clock (clock),
        .i_reset (reset),
        .i_zera  (r_estado != ACESO),
        .i_conta (r_estado == ACESO),
        .o_fim   (w_fim_aceso)
    );

    contador_m #(.M(T_APAGADO), .W(TMR_W)) u_tmr_apagado (
        .i_clock (clock),
        .i_reset (reset),
        .i_zera  (r_estado != APAGADO),
        .i_conta (r_estado == APAGADO),
        .o_fim   (w_fim_apagado)
    );

    // Next-state and next-output logic of the playback FSM.
    always_comb begin
        w_prox_estado   = r_estado;
        w_prox_endereco = r_endereco;
        w_prox_rodada   = r_rodada;
        w_prox_leds     = r_leds;
        case (r_estado)
            INICIAL: begin
                w_prox_leds = {DATA_W{1'b0}};
                if (iniciar) begin
                    w_prox_rodada   = rodada;
                    w_prox_endereco = {ADDR_W{1'b0}};
                    w_prox_estado   = CARREGA;
                end else begin
                    w_prox_estado = INICIAL;
                end
            end
            CARREGA: begin
                w_prox_leds   = mem_dado;
                w_prox_estado = ACESO;
            end
            ACESO: begin
                if (w_fim_aceso) begin
                    w_prox_leds   = {DATA_W{1'b0}};
                    w_prox_estado = APAGADO;
                end else begin
                    w_prox_estado = ACESO;
                end
            end
            APAGADO: begin
                w_prox_leds = {DATA_W{1'b0}};
                if (w_fim_apagado) begin
                    // Stop on the last entry before incrementing, so the address never wraps.
                    if (r_endereco == r_rodada) begin
                        w_prox_estado = FIM;
                    end else begin
                        w_prox_endereco = r_endereco + ADDR_W'(1);
                        w_prox_estado   = CARREGA;
                    end
                end else begin
                    w_prox_estado = APAGADO;
                end
            end
            FIM: begin
                w_prox_leds   = {DATA_W{1'b0}};
                w_prox_estado = INICIAL;
            end
            default: begin
                w_prox_leds   = {DATA_W{1'b0}};
                w_prox_estado = INICIAL;
            end
        endcase
    end

    // State and registered outputs; ocupado/pronto are decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_endereco <= {ADDR_W{1'b0}};
            r_rodada   <= {ADDR_W{1'b0}};
            r_leds     <= {DATA_W{1'b0}};
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_estado   <= w_prox_estado;
            r_endereco <= w_prox_endereco;
            r_rodada   <= w_prox_rodada;
            r_leds     <= w_prox_leds;
            r_ocupado  <= (w_prox_estado != INICIAL);
            r_pronto   <= (w_prox_estado == FIM);
        end
    end

    assign mem_endereco = r_endereco;
    assign leds         = r_leds;
    assign ocupado      = r_ocupado;
    assign pronto       = r_pronto;

`ifdef MOSTRA_SEQUENCIA_DB_EN
    assign db_estado   = r_estado;
    assign db_endereco = r_endereco;
`endif

endmodule

// File: tb/tb_mostra_sequencia.sv
// Bench for mostra_sequencia: a hand-written vector table, directed playback scenarios and
// randomized traffic, all checked against a timeline model of the playback.
module tb_mostra_sequencia;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int TA     = 3;
    localparam int TP     = 2;
    localparam int P      = 1 + TA + TP;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              iniciar = 1'b0;
    logic [ADDR_W-1:0] rodada = '0;
    logic [ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0] mem_dado;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              pronto;
`ifdef MOSTRA_SEQUENCIA_DB_EN
    logic [3:0]        db_estado;
    logic [ADDR_W-1:0] db_endereco;
`endif

    logic [DATA_W-1:0] mem [16];
    assign mem_dado = mem[mem_endereco];

    mostra_sequencia #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ACESO(TA), .T_APAGADO(TP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .rodada       (rodada),
        .mem_endereco (mem_endereco),
        .mem_dado     (mem_dado),
        .leds         (leds),
        .ocupado      (ocupado),
`ifdef MOSTRA_SEQUENCIA_DB_EN
        .db_estado    (db_estado),
        .db_endereco  (db_endereco),
`endif
        .pronto       (pronto)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Model: playback is a timeline of (rodada+1) slots of P cycles followed by one pronto cycle.
    bit m_ativo = 1'b0;
    int m_t = 0;
    int m_r = 0;
    int m_addr_idle = 0;

    task automatic checar(input string nome, input int atual, input int esperado);
        n_cmp++;
        if (atual != esperado) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic modelo_borda();
        if (reset) begin
            m_ativo = 1'b0;
            m_addr_idle = 0;
        end else if (!m_ativo) begin
            if (iniciar) begin
                m_ativo = 1'b1;
                m_t = 0;
                m_r = int'(rodada);
            end
        end else begin
            m_t++;
            if (m_t == (m_r + 1) * P + 1) begin
                m_ativo = 1'b0;
                m_addr_idle = m_r;
            end
        end
    endtask

    task automatic esperado(output int e_leds, output int e_oc, output int e_pr, output int e_addr);
        int e;
        int ph;
        if (!m_ativo) begin
            e_leds = 0; e_oc = 0; e_pr = 0; e_addr = m_addr_idle;
        end else if (m_t < (m_r + 1) * P) begin
            e  = m_t / P;
            ph = m_t % P;
            e_leds = (ph >= 1 && ph <= TA) ? int'(mem[e]) : 0;
            e_oc = 1; e_pr = 0; e_addr = e;
        end else begin
            e_leds = 0; e_oc = 1; e_pr = 1; e_addr = m_r;
        end
    endtask

    task automatic ciclo();
        int el, eo, ep, ea;
        @(posedge clock);
        modelo_borda();
        #1;
        esperado(el, eo, ep, ea);
        checar("leds", int'(leds), el);
        checar("ocupado", int'(ocupado), eo);
        checar("pronto", int'(pronto), ep);
        checar("mem_endereco", int'(mem_endereco), ea);
    endtask

    task automatic esperar_ocioso();
        int k;
        iniciar = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (!ocupado) break;
            ciclo();
        end
        checar("timeout_ocioso", k, (k < 2000) ? k : -1);
    endtask

    task automatic rodar(input int r, input bit manter, input int r_novo, output int lat);
        iniciar = 1'b1;
        rodada  = ADDR_W'(r);
        ciclo();
        if (!manter) iniciar = 1'b0;
        lat = 0;
        for (int k = 1; k <= 2000; k++) begin
            if (k == 3) rodada = ADDR_W'(r_novo);
            ciclo();
            if (pronto) begin
                lat = k;
                break;
            end
        end
        checar("latencia_pronto", lat, (r + 1) * P);
    endtask

    typedef struct {
        bit       rst;
        bit       ini;
        bit [3:0] rod;
        bit [3:0] leds;
        bit       oc;
        bit       pr;
        bit [3:0] addr;
    } vetor_t;

    vetor_t tab [9];

    initial begin
        int lat;
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(4'b0001 << (i % 4));

        // rodada=0 playback written out cycle by cycle: 3 lit, 2 dark, pronto on the 6th edge.
        tab[0] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0};
        tab[1] = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0};
        tab[2] = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0};
        tab[3] = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0};
        tab[4] = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0};
        tab[5] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0};
        tab[6] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0};
        tab[7] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0};
        tab[8] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0};

        for (int i = 0; i < 9; i++) begin
            reset   = tab[i].rst;
            iniciar = tab[i].ini;
            rodada  = tab[i].rod;
            @(posedge clock);
            modelo_borda();
            #1;
            checar("tab_leds", int'(leds), int'(tab[i].leds));
            checar("tab_ocupado", int'(ocupado), int'(tab[i].oc));
            checar("tab_pronto", int'(pronto), int'(tab[i].pr));
            checar("tab_endereco", int'(mem_endereco), int'(tab[i].addr));
        end
        reset = 1'b0;
        iniciar = 1'b0;

        // Four entries 1,2,4,8.
        esperar_ocioso();
        rodar(3, 1'b0, 3, lat);
        ciclo();

        // iniciar held: one playback, then a second one starts after FIM.
        esperar_ocioso();
        rodar(1, 1'b1, 1, lat);
        ciclo();
        ciclo();
        checar("segunda_partida", int'(ocupado), 1);
        esperar_ocioso();

        // Full 16-entry sequence with distinct contents; must not wrap to address 0.
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(15 - i);
        rodar(15, 1'b0, 15, lat);
        ciclo();
        checar("sem_wrap", int'(mem_endereco), 15);
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(4'b0001 << (i % 4));

        // rodada changed after the latch.
        esperar_ocioso();
        rodar(1, 1'b0, 5, lat);
        ciclo();
        checar("para_em_1", int'(mem_endereco), 1);

        // Reset during the lit phase of entry 2.
        esperar_ocioso();
        iniciar = 1'b1;
        rodada  = 4'd3;
        ciclo();
        iniciar = 1'b0;
        for (int k = 0; k < 2 * P + 2; k++) ciclo();
        checar("aceso_entrada2", int'(leds), 4);
        reset = 1'b1;
        ciclo();
        checar("reset_leds", int'(leds), 0);
        checar("reset_ocupado", int'(ocupado), 0);
        checar("reset_endereco", int'(mem_endereco), 0);
        reset = 1'b0;
        for (int k = 0; k < 4 * P; k++) ciclo();

        // Randomized traffic: random memory, noisy iniciar/rodada, rare resets.
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(4'b0001 << $urandom_range(0, 3));
        for (int k = 0; k < 3000; k++) begin
            iniciar = ($urandom_range(0, 3) == 0);
            rodada  = ADDR_W'($urandom_range(0, 15));
            reset   = ($urandom_range(0, 199) == 0);
            ciclo();
        end
        reset = 1'b0;
        esperar_ocioso();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
